// File: rtl/fork_ctrl_pkg.sv
// Shared types for the fork/join control blocks: branch count, FSM states,
// branch mask type and the join predicates used by the scheduler.
package fork_ctrl_pkg;
  localparam int NUM_BRANCH = 3;

  typedef enum logic [1:0] {IDLE, RISE, FALL, DONE} fork_state_e;

  typedef logic [NUM_BRANCH-1:0] branch_mask_t;

  // Disabled branches are don't-care, so an empty mask joins immediately.
  function automatic logic join_hi(branch_mask_t m, branch_mask_t a);
    return &(~m | a);
  endfunction

  function automatic logic join_lo(branch_mask_t m, branch_mask_t a);
    return ~|(m & a);
  endfunction
endpackage

// File: rtl/fork3_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// last+1, wrapping modulo NUM_REQ (not modulo a power of two).
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k;
      k = int'(last) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      j = IW'(k);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/fork3_sched.sv
// Shares one three-branch fork stage among NUM_REQ requesters: round-robin
// grant, four-phase RZ handshake on the branch lines, per-phase timeout.
module fork3_sched
  import fork_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 200
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*NUM_BRANCH-1:0] mask_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_BRANCH-1:0]         req_out_o,
  input  logic [NUM_BRANCH-1:0]         ack_out_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  fork_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    last_q, last_d, idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  branch_mask_t     mask_q, mask_d, req_out_q, req_out_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, erro_q, erro_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  branch_mask_t       mask_sel;
  logic               phase_to;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req  (req_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_comb begin
    mask_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_gnt[i]) mask_sel = mask_sel | mask_i[i*NUM_BRANCH +: NUM_BRANCH];
  end

  assign phase_to = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    mask_d    = mask_q;
    req_out_d = req_out_q;
    err_d     = err_q;
    done_d    = 1'b0;
    erro_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = RISE;
          gnt_d     = pick_gnt;
          idx_d     = pick_idx;
          mask_d    = mask_sel;
          req_out_d = mask_sel;
          err_d     = 1'b0;
          cnt_d     = '0;
        end
      end
      RISE: begin
        // Join wins over timeout when both happen on the same cycle.
        if (join_hi(mask_q, ack_out_i) || phase_to) begin
          if (!join_hi(mask_q, ack_out_i)) err_d = 1'b1;
          state_d   = FALL;
          req_out_d = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FALL: begin
        if (join_lo(mask_q, ack_out_i) || phase_to) begin
          state_d = DONE;
          done_d  = 1'b1;
          erro_d  = err_q | ~join_lo(mask_q, ack_out_i);
          err_d   = err_q | ~join_lo(mask_q, ack_out_i);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = idx_q;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      idx_q     <= '0;
      gnt_q     <= '0;
      mask_q    <= '0;
      req_out_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      mask_q    <= mask_d;
      req_out_q <= req_out_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign req_out_o = req_out_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = erro_q;
endmodule

// File: tb/tb_fork3_sched.sv
// Scoreboard bench for fork3_sched: expected grant/mask/error pushed per
// transaction, popped on each done pulse; timing checked in the stimulus.
module tb_fork3_sched;
  localparam int NR = 3;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*3-1:0] mask;
  logic [NR-1:0]   gnt;
  logic [2:0]      req_out, ack;
  logic            busy, done, err;

  always #5 clk = ~clk;

  fork3_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .mask_i(mask), .gnt_o(gnt),
    .req_out_o(req_out), .ack_out_i(ack), .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct { logic [NR-1:0] gnt; logic [2:0] mask; logic err; } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int ack_dly = 0;
  logic [2:0] force_hi = '0, force_lo = '0;
  logic [2:0] hist [0:7];
  logic [NR-1:0] g_seen;
  logic [2:0] m_seen;
  int gnt_cyc = 0, done_at = 0, req_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Branch model: each ack echoes req_out after ack_dly cycles, with overrides.
  initial begin
    for (int k = 0; k < 8; k++) hist[k] = '0;
    ack = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = req_out;
      ack = (hist[ack_dly] & ~force_lo) | force_hi;
    end
  end

  initial begin
    logic [NR-1:0] pg;
    exp_t e;
    pg = '0;
    forever begin
      @(negedge clk);
      if (gnt != 0 && pg == 0) begin
        g_seen  = gnt;
        m_seen  = req_out;
        gnt_cyc = cyc;
      end
      if (done) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_gnt", gnt, e.gnt);
          chk("grant_mask", m_seen, e.mask);
          chk("done_err", err, e.err);
        end
      end
      pg = gnt;
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk("done_seen", done, 1);
    done_at = cyc;
  endtask

  task automatic push_exp(input int r, input logic [2:0] m, input logic e);
    exp_t x;
    x.gnt = NR'(1 << r);
    x.mask = m;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic txn(input int r, input logic [2:0] m, input logic e, input int budget);
    @(negedge clk);
    mask[r*3 +: 3] = m;
    req[r] = 1'b1;
    req_cyc = cyc;
    push_exp(r, m, e);
    wait_done(budget);
    req[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_gnt(input int budget);
    int n;
    n = 0;
    while (gnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_seen", gnt != 0, 1);
  endtask

  initial begin
    int prev, hi;
    rst = 1'b1; req = '0; mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_req_out", req_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;

    // single handshake, acks lag 2 cycles
    ack_dly = 2;
    txn(0, 3'b111, 1'b0, 100);
    chk("single_busy_in_done", busy, 1);
    repeat (8) @(negedge clk);

    // partial mask, unmasked ack[1] stuck high
    force_hi = 3'b010; ack_dly = 1;
    txn(1, 3'b101, 1'b0, 100);
    repeat (8) @(negedge clk);
    force_hi = '0;

    // round robin from reset with immediate acks
    do_reset();
    ack_dly = 0;
    @(negedge clk);
    mask = {3'b111, 3'b111, 3'b111};
    push_exp(0, 3'b111, 0); push_exp(1, 3'b111, 0);
    push_exp(2, 3'b111, 0); push_exp(0, 3'b111, 0);
    req = 3'b111;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(50);
      if (k > 0) chk("rr_spacing", done_at - prev, 4);
      prev = done_at;
    end
    req = '0;
    repeat (8) @(negedge clk);

    // rise timeout, acks stuck low
    force_lo = 3'b111;
    @(negedge clk);
    mask[2:0] = 3'b111; req[0] = 1'b1;
    push_exp(0, 3'b111, 1'b1);
    wait_gnt(20);
    hi = 0;
    while (req_out == 3'b111 && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    chk("rise_cycles", hi, TO);
    wait_done(20);
    req[0] = 1'b0;
    force_lo = '0;
    repeat (8) @(negedge clk);

    // join on the last allowed cycle of each phase: no error
    ack_dly = TO - 1;
    txn(1, 3'b111, 1'b0, 100);
    repeat (8) @(negedge clk);
    // one cycle later: timeout
    ack_dly = TO;
    txn(2, 3'b111, 1'b1, 100);
    repeat (8) @(negedge clk);

    // reset during FALL
    ack_dly = 2;
    @(negedge clk);
    mask[2:0] = 3'b111; req[0] = 1'b1;
    wait_gnt(20);
    hi = 0;
    while (req_out != 0 && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    chk("fall_busy", busy, 1);
    chk("fall_gnt", gnt, 3'b001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_req_out", req_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0; req = '0;
    sb.delete();
    repeat (8) @(negedge clk);

    // empty mask: request seen at edge t, grant from t+1, done at t+3
    txn(2, 3'b000, 1'b0, 50);
    chk("empty_grant_lat", gnt_cyc - req_cyc, 1);
    chk("empty_done_lat", done_at - req_cyc, 3);
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end
endmodule
